dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the RV32I 5-stage pipeline; services the load/store request the memory-access stage issues (address, write data, read/write enables, size, sign).
- Holds a word-organised single-port data array with a configurable number of wait states.
- Returns sign- or zero-extended load data and an error flag.
- Drives a stall line to the hazard unit until the response is delivered.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- WAIT_STATES, 1, extra cycles between acceptance and memory access; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_ni  input  1  synchronous active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_addr_i  input  32  byte address.
- req_rd_en_i  input  1  load request.
- req_wr_en_i  input  1  store request.
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sign_i  input  1  1 = sign-extend load, 0 = zero-extend.
- req_wdata_i  input  32  store data, right-justified.
- rsp_valid_o  output  1  one-cycle response strobe.
- rsp_rdata_o  output  32  extended load data.
- rsp_err_o  output  1  request was illegal and was not performed.
- busy_o  output  1  stall request to the hazard unit.

Behaviour:
- Reset: one clock, reset is synchronous and active-low. While rst_ni=0 at a clock edge:
  - FSM goes to IDLE.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0, req_ready_o=0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- req_ready_o=1 only in IDLE with rst_ni=1. A request is accepted when req_valid_i and req_ready_o are both high. On acceptance, latch addr, size, sign, wdata, rd_en and wr_en.
- Transitions:
  - IDLE to WAIT on acceptance when WAIT_STATES>0; a counter loads WAIT_STATES-1.
  - IDLE to RESP on acceptance when WAIT_STATES=0.
  - WAIT decrements the counter and moves to RESP when it reaches 0.
  - RESP always returns to IDLE.
- Memory access (array read or byte-lane write) happens on the clock edge that enters RESP.
- rsp_valid_o is high for exactly the one RESP cycle, i.e. WAIT_STATES+1 cycles after the acceptance edge. No request is accepted in RESP, so peak throughput is one request per WAIT_STATES+2 cycles.
- busy_o (combinational):
  - High in IDLE when req_valid_i=1 and the request is accepted.
  - High throughout WAIT.
  - Low in RESP, so the pipeline advances in the same cycle the response is valid.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- Stores write only the selected lanes; other bytes keep their value:
  - byte: lane addr[1:0] receives wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
  - word: all four lanes receive wdata.
- Loads extract the addressed byte or half, then sign-extend if req_sign_i=1, else zero-extend. Word loads ignore req_sign_i.
- Store response: rsp_rdata_o=0 in the RESP cycle.
- Error cases (rsp_err_o=1, no array write, rsp_rdata_o=0):
  - req_size_i=11.
  - req_rd_en_i and req_wr_en_i both high.
- Request with neither enable: a no-op that still completes the full latency, with rsp_err_o=0 and rsp_rdata_o=0.
- rsp_rdata_o and rsp_err_o hold their RESP values until the next RESP; they are only meaningful while rsp_valid_o=1.
- Reset while in WAIT drops the pending request; a store not yet performed never writes.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠00, is an error. rsp_err_o=1, no write, rdata=0, with the normal latency.
- Undefined: misaligned addresses are force-aligned (half clears addr[0], word clears addr[1:0]) and complete normally with rsp_err_o=0.

Test Plan:
- Reset, WAIT_STATES=1, word store 0xDEADBEEF to 0x100, then word load 0x100 -> rsp_valid_o exactly 2 cycles after each acceptance; load data 0xDEADBEEF; busy_o high for 2 cycles per request.
- Byte store 0x80 to 0x103 over 0x00000000, then load byte 0x103 with sign=1 and sign=0 -> 0xFFFFFF80 and 0x00000080; word load of 0x100 returns 0x80000000.
- Half store 0x1234 to 0x202, load word 0x200 -> 0x12340000; a load of 0x200 with size=11 -> rsp_err_o=1, rdata 0, no state change.
- WAIT_STATES=0, back-to-back valid requests -> response 1 cycle after acceptance; req_ready_o low in RESP; one request accepted every 2 cycles.
- Store to 0x300 accepted with WAIT_STATES=3, rst_ni pulsed low in WAIT, then load 0x300 -> prior contents returned; all outputs 0 during reset.
- Half load at 0x101: with DMEM_MISALIGN_TRAP_EN -> rsp_err_o=1; without -> data of half at 0x100, rsp_err_o=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I MEM stage: word array, WAIT_STATES latency, extended loads, stall line.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors instead of force-aligning them.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_rd_en_i,
  input  logic        req_wr_en_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        sign_q, rd_q, wr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, access;
  logic [31:0]   a_addr, a_wdata, a_word, a_wword, a_rdata;
  logic [1:0]    a_size, a_off;
  logic          a_sign, a_rd, a_wr, a_err;
  logic [AW-1:0] a_idx;
  logic [3:0]    a_be;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          unused_addr_bits;

  assign req_ready_o = rst_ni && (state_q == S_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign busy_o      = accept || (rst_ni && (state_q == S_WAIT));
  assign rsp_valid_o = rst_ni && (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
            access  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so use the live request
  assign a_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
  assign a_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
  assign a_size  = (state_q == S_IDLE) ? req_size_i  : size_q;
  assign a_sign  = (state_q == S_IDLE) ? req_sign_i  : sign_q;
  assign a_rd    = (state_q == S_IDLE) ? req_rd_en_i : rd_q;
  assign a_wr    = (state_q == S_IDLE) ? req_wr_en_i : wr_q;
  assign a_idx   = a_addr[AW+1:2];
  assign a_word  = mem[a_idx];
  assign unused_addr_bits = ^a_addr[31:AW+2];

  always_comb begin : decode
    a_err = (a_size == 2'b11) || (a_rd && a_wr);
    a_off = a_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((a_size == 2'b01 && a_addr[0]) || (a_size == 2'b10 && a_addr[1:0] != 2'b00)) a_err = 1'b1;
`else
    if (a_size == 2'b01) a_off[0] = 1'b0;
    else if (a_size == 2'b10) a_off = 2'b00;
`endif
    a_wword = a_wdata;
    case (a_size)
      2'b00: begin a_be = 4'b0001 << a_off; a_wword = {4{a_wdata[7:0]}}; end
      2'b01: begin a_be = a_off[1] ? 4'b1100 : 4'b0011; a_wword = {2{a_wdata[15:0]}}; end
      2'b10: a_be = 4'b1111;
      default: a_be = 4'b0000;
    endcase
    if (a_err || !a_wr) a_be = 4'b0000;
    byte_v  = a_word[{a_off, 3'b000} +: 8];
    half_v  = a_off[1] ? a_word[31:16] : a_word[15:0];
    a_rdata = 32'd0;
    if (a_rd && !a_err) begin
      case (a_size)
        2'b00:   a_rdata = a_sign ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
        2'b01:   a_rdata = a_sign ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
        default: a_rdata = a_word;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        rdata_q <= a_rdata;
        err_q   <= a_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      size_q  <= req_size_i;
      sign_q  <= req_sign_i;
      rd_q    <= req_rd_en_i;
      wr_q    <= req_wr_en_i;
    end
  end

  // Array is never reset; a reset edge suppresses any pending write
  always_ff @(posedge clk) begin
    if (rst_ni && access) begin
      for (int b = 0; b < 4; b++) begin
        if (a_be[b]) mem[a_idx][8*b +: 8] <= a_wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (WAIT_STATES 1, 0, 3) against a byte-level memory model.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design.
module tb_dmem_responder;

  localparam int MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        req_rd    [3];
  logic        req_wr    [3];
  logic [1:0]  req_size  [3];
  logic        req_sign  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  logic [7:0]  ref_mem [3][MEM_BYTES];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_ni(rst_n[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr[0]), .req_rd_en_i(req_rd[0]), .req_wr_en_i(req_wr[0]),
    .req_size_i(req_size[0]), .req_sign_i(req_sign[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]), .busy_o(busy[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_ni(rst_n[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr[1]), .req_rd_en_i(req_rd[1]), .req_wr_en_i(req_wr[1]),
    .req_size_i(req_size[1]), .req_sign_i(req_sign[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]), .busy_o(busy[1]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_ni(rst_n[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_addr_i(req_addr[2]), .req_rd_en_i(req_rd[2]), .req_wr_en_i(req_wr[2]),
    .req_size_i(req_size[2]), .req_sign_i(req_sign[2]), .req_wdata_i(req_wdata[2]),
    .rsp_valid_o(rsp_valid[2]), .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]), .busy_o(busy[2]));

  // Byte-addressed view of what a load/store should do
  task automatic model_access(input int d, input logic rd, input logic wr, input logic [1:0] size,
                              input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
    int base, n;
    logic [31:0] v;
    base = int'(addr % MEM_BYTES);
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    err = (size == 2'b11) || (rd && wr);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (size != 2'b11 && (base % n) != 0) err = 1'b1;
`else
    base = base - (base % n);
`endif
    rdata = 32'd0;
    if (!err && wr) for (int i = 0; i < n; i++) ref_mem[d][base+i] = wdata[8*i +: 8];
    if (!err && rd) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[d][base+i]) << (8*i));
      if (sign && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rdata = v;
    end
  endtask

  // Drive one request, measure latency/busy cycles, capture the response and the model's expectation
  task automatic op(input int d, input logic rd, input logic wr, input logic [1:0] size, input logic sign,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    output logic [31:0] got_d, output logic [31:0] exp_d,
                    output logic got_e, output logic exp_e,
                    output int lat, output int busy_cyc, output logic quiet);
    int guard;
    logic seen;
    got_d = 32'd0; got_e = 1'b0; lat = -1; quiet = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_rd[d] = rd; req_wr[d] = wr; req_size[d] = size;
    req_sign[d] = sign; req_addr[d] = addr; req_wdata[d] = wdata;
    #1;
    guard = 0;
    while (req_ready[d] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    seen = (req_ready[d] === 1'b1);
    busy_cyc = (busy[d] === 1'b1) ? 1 : 0;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    if (seen) begin
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (rsp_valid[d] === 1'b1) begin
          got_d = rsp_rdata[d]; got_e = rsp_err[d]; lat = c;
          quiet = (busy[d] === 1'b0) && (req_ready[d] === 1'b0);
          break;
        end
        if (busy[d] === 1'b1) busy_cyc++;
      end
    end
    model_access(d, rd, wr, size, sign, addr, wdata, exp_d, exp_e);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_rd[d] = 1'b0; req_wr[d] = 1'b0;
      req_size[d] = 2'b10; req_sign[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (req_ready[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready[%0d]: got %b expected 0", d, req_ready[d]); end
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy[%0d]: got %b expected 0", d, busy[d]); end
      checks++; if (rsp_valid[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid[%0d]: got %b expected 0", d, rsp_valid[d]); end
      checks++; if (rsp_rdata[d] !== 32'd0 || rsp_err[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp[%0d]: got %h/%b expected 0/0", d, rsp_rdata[d], rsp_err[d]); end
      rst_n[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset[%0d]: got %b expected 1", d, req_ready[d]); end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] gd, ed; logic ge, ee, q; int lat, bc;
    op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, gd, ed, ge, ee, lat, bc, q);
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (bc != 2) begin errors++; $display("[TB] FAIL sw_busy_cycles: got %0d expected 2", bc); end
    checks++; if (gd !== 32'd0 || ge !== 1'b0) begin errors++; $display("[TB] FAIL sw_resp: got %h/%b expected 0/0", gd, ge); end
    checks++; if (q !== 1'b1) begin errors++; $display("[TB] FAIL resp_busy_ready_low: got %b expected 1", q); end
    op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, gd, ed, ge, ee, lat, bc, q);
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL lw_latency: got %0d expected 2", lat); end
    checks++; if (bc != 2) begin errors++; $display("[TB] FAIL lw_busy_cycles: got %0d expected 2", bc); end
    checks++; if (gd !== 32'hDEADBEEF || ge !== 1'b0) begin errors++; $display("[TB] FAIL lw_data: got %h/%b expected deadbeef/0", gd, ge); end
  endtask

  task automatic test_byte_sign();
    logic [31:0] gd, ed; logic ge, ee, q; int lat, bc;
    op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, gd, ed, ge, ee, lat, bc, q);
    op(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h80, gd, ed, ge, ee, lat, bc, q);
    op(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, gd, ed, ge, ee, lat, bc, q);
    checks++; if (gd !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_signed: got %h expected ffffff80", gd); end
    op(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, gd, ed, ge, ee, lat, bc, q);
    checks++; if (gd !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_unsigned: got %h expected 00000080", gd); end
    op(0, 1'b1, 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, gd, ed, ge, ee, lat, bc, q);
    checks++; if (gd !== 32'h80000000) begin errors++; $display("[TB] FAIL sb_lane: got %h expected 80000000", gd); end
  endtask

  task automatic test_half_and_errors();
    logic [31:0] gd, ed; logic ge, ee, q; int lat, bc;
    op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0, gd, ed, ge, ee, lat, bc, q);
    op(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'hABCD1234, gd, ed, ge, ee, lat, bc, q);
    op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, gd, ed, ge, ee, lat, bc, q);
    checks++; if (gd !== 32'h12340000) begin errors++; $display("[TB] FAIL sh_lane: got %h expected 12340000", gd); end
    op(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h200, 32'h0, gd, ed, ge, ee, lat, bc, q);
    checks++; if (ge !== 1'b1 || gd !== 32'd0) begin errors++; $display("[TB] FAIL size11_err: got %h/%b expected 0/1", gd, ge); end
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL size11_latency: got %0d expected 2", lat); end
    op(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h200, 32'hFFFFFFFF, gd, ed, ge, ee, lat, bc, q);
    checks++; if (ge !== 1'b1 || gd !== 32'd0) begin errors++; $display("[TB] FAIL rdwr_err: got %h/%b expected 0/1", gd, ge); end
    op(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h200, 32'hFFFFFFFF, gd, ed, ge, ee, lat, bc, q);
    checks++; if (ge !== 1'b0 || gd !== 32'd0 || lat != 2) begin errors++; $display("[TB] FAIL noop: got %h/%b lat %0d expected 0/0 lat 2", gd, ge, lat); end
    op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, gd, ed, ge, ee, lat, bc, q);
    checks++; if (gd !== 32'h12340000 || ge !== 1'b0) begin errors++; $display("[TB] FAIL err_no_write: got %h/%b expected 12340000/0", gd, ge); end
  endtask

  task automatic test_misalign();
    logic [31:0] gd, ed; logic ge, ee, q; int lat, bc;
    op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, gd, ed, ge, ee, lat, bc, q);
    op(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h101, 32'h0, gd, ed, ge, ee, lat, bc, q);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (ge !== 1'b1 || gd !== 32'd0) begin errors++; $display("[TB] FAIL lh_misalign: got %h/%b expected 0/1", gd, ge); end
`else
    checks++; if (ge !== 1'b0 || gd !== 32'hFFFFF00D) begin errors++; $display("[TB] FAIL lh_misalign: got %h/%b expected fffff00d/0", gd, ge); end
`endif
    op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, gd, ed, ge, ee, lat, bc, q);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (ge !== 1'b1 || gd !== 32'd0) begin errors++; $display("[TB] FAIL lw_misalign: got %h/%b expected 0/1", gd, ge); end
`else
    checks++; if (ge !== 1'b0 || gd !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL lw_misalign: got %h/%b expected cafef00d/0", gd, ge); end
`endif
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL misalign_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] gd, ed, e; logic ge, ee, q, accepted; int lat, bc, k, nresp;
    int acc_cyc[$];
    logic [31:0] expq[$];
    for (int i = 0; i < 4; i++)
      op(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40 + 32'(4*i), $urandom, gd, ed, ge, ee, lat, bc, q);
    checks++; if (lat != 1) begin errors++; $display("[TB] FAIL ws0_latency: got %0d expected 1", lat); end
    k = 0; nresp = 0;
    @(negedge clk);
    req_valid[1] = 1'b1; req_rd[1] = 1'b1; req_wr[1] = 1'b0; req_size[1] = 2'b10;
    req_sign[1] = 1'b0; req_addr[1] = 32'h40;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rsp_valid[1] === 1'b1) begin
        nresp++;
        checks++; if (expq.size() == 0 || rsp_rdata[1] !== expq[0]) begin errors++; $display("[TB] FAIL b2b_data: got %h expected %h", rsp_rdata[1], (expq.size() > 0) ? expq[0] : 32'd0); end
        checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_in_resp: got %b expected 0", req_ready[1]); end
        checks++; if (acc_cyc.size() == 0 || acc_cyc[$] != c - 1) begin errors++; $display("[TB] FAIL b2b_resp_delay: resp at %0d expected one cycle after acceptance", c); end
        if (expq.size() > 0) void'(expq.pop_front());
      end
      accepted = (req_valid[1] === 1'b1) && (req_ready[1] === 1'b1);
      if (accepted) begin
        acc_cyc.push_back(c);
        model_access(1, 1'b1, 1'b0, 2'b10, 1'b0, req_addr[1], 32'd0, e, ee);
        expq.push_back(e);
      end
      @(posedge clk);
      #1;
      if (accepted) begin
        k++;
        if (k == 4) req_valid[1] = 1'b0;
        else req_addr[1] = 32'h40 + 32'(4*k);
      end
    end
    checks++; if (nresp != 4) begin errors++; $display("[TB] FAIL b2b_resp_count: got %0d expected 4", nresp); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] != 2) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 2", acc_cyc[i] - acc_cyc[i-1]); end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] gd, ed; logic ge, ee, q; int lat, bc, guard;
    op(2, 1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'h11223344, gd, ed, ge, ee, lat, bc, q);
    checks++; if (lat != 4 || bc != 4) begin errors++; $display("[TB] FAIL ws3_timing: got lat %0d busy %0d expected 4/4", lat, bc); end
    op(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, gd, ed, ge, ee, lat, bc, q);
    @(negedge clk);
    req_valid[2] = 1'b1; req_rd[2] = 1'b0; req_wr[2] = 1'b1; req_size[2] = 2'b10; req_addr[2] = 32'h300; req_wdata[2] = 32'hAABBCCDD;
    #1;
    guard = 0;
    while (req_ready[2] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("[TB] FAIL busy_in_wait: got %b expected 1", busy[2]); end
    rst_n[2] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++; if (req_ready[2] !== 1'b0 || busy[2] !== 1'b0 || rsp_valid[2] !== 1'b0 || rsp_rdata[2] !== 32'd0 || rsp_err[2] !== 1'b0)
        begin errors++; $display("[TB] FAIL outputs_in_reset: got rdy %b busy %b vld %b data %h err %b expected all 0", req_ready[2], busy[2], rsp_valid[2], rsp_rdata[2], rsp_err[2]); end
    end
    rst_n[2] = 1'b1;
    op(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, gd, ed, ge, ee, lat, bc, q);
    checks++; if (gd !== 32'h11223344 || lat != 4) begin errors++; $display("[TB] FAIL dropped_store: got %h lat %0d expected 11223344 lat 4", gd, lat); end
  endtask

  task automatic test_random();
    logic [31:0] gd, ed, addr; logic ge, ee, q, rd, wr; logic [1:0] size; int lat, bc, r;
    for (int i = 0; i < 16; i++)
      op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'(4*i), $urandom, gd, ed, ge, ee, lat, bc, q);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      rd = (r <= 3) || (r == 8);
      wr = (r >= 4 && r <= 8);
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      op(0, rd, wr, size, 1'($urandom_range(0, 1)), addr, $urandom, gd, ed, ge, ee, lat, bc, q);
      checks++; if (gd !== ed || ge !== ee) begin errors++; $display("[TB] FAIL rand_resp[%0d] rd %b wr %b size %b addr %h: got %h/%b expected %h/%b", i, rd, wr, size, addr, gd, ge, ed, ee); end
      checks++; if (lat != 2 || bc != 2) begin errors++; $display("[TB] FAIL rand_timing[%0d]: got lat %0d busy %0d expected 2/2", i, lat, bc); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_sign();
    test_half_and_errors();
    test_misalign();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
